// File: rtl/pinv_ram_loader.sv
// Packs a WORD_W-bit stream into ROW_W-bit rows and writes DEPTH rows through RAM port A.
// Define PINV_LOADER_CSUM_EN to enable the running checksum on csum; otherwise csum reads 0.
module pinv_ram_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int WORD_W = 32,
  parameter int ROW_W  = 1152
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [ROW_W-1:0]  dina,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] csum
);
  localparam int WORDS_PER_ROW = ROW_W / WORD_W;
  localparam int WC_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]  buf_q, buf_d;
  logic              s_ready_q, wea_q, busy_q, done_q;
  logic [ADDR_W-1:0] addra_q;
  logic [ROW_W-1:0]  dina_q;
  logic              xfer, start_ok;

  // s_ready_q is only ever high in FILL, so this is the full handshake
  assign xfer     = s_valid && s_ready_q;
  assign start_ok = start && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    buf_d      = buf_q;
    case (state_q)
      IDLE: if (start) begin
        word_cnt_d = '0;
        row_cnt_d  = '0;
        state_d    = FILL;
      end
      FILL: if (xfer) begin
        buf_d[int'(word_cnt_q)*WORD_W +: WORD_W] = s_data;
        if (word_cnt_q == WC_W'(WORDS_PER_ROW-1)) begin
          word_cnt_d = '0;
          state_d    = WRITE;
        end else begin
          word_cnt_d = word_cnt_q + WC_W'(1);
        end
      end
      WRITE: if (row_cnt_q == ADDR_W'(DEPTH-1)) begin
        state_d = DONE;
      end else begin
        row_cnt_d = row_cnt_q + ADDR_W'(1);
        state_d   = FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All handshake and RAM-port outputs are registered from the next state
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      buf_q      <= '0;
      s_ready_q  <= 1'b0;
      wea_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      buf_q      <= buf_d;
      s_ready_q  <= (state_d == FILL);
      wea_q      <= (state_d == WRITE);
      busy_q     <= (state_d == FILL) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
      if (state_q == FILL && state_d == WRITE) begin
        addra_q <= row_cnt_q;
        dina_q  <= buf_d;
      end
    end
  end

  assign s_ready = s_ready_q;
  assign wea     = wea_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign addra   = addra_q;
  assign dina    = dina_q;

`ifdef PINV_LOADER_CSUM_EN
  logic [WORD_W-1:0] csum_q;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)        csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (xfer)     csum_q <= csum_q + s_data;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_pinv_ram_loader.sv
// Randomized self-checking bench for pinv_ram_loader: stream-order row model, latency, checksum.
module tb_pinv_ram_loader;
  localparam int AW = 5, DEPTH = 32, WW = 32, RW = 1152, WPR = RW / WW, NW = DEPTH * WPR;

  logic          clka = 1'b0;
  logic          rst_n, start, s_valid, s_ready, wea, busy, done;
  logic [WW-1:0] s_data, csum;
  logic [AW-1:0] addra;
  logic [RW-1:0] dina;

  always #5 clka = ~clka;

  pinv_ram_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .WORD_W(WW), .ROW_W(RW)) dut (
    .clka(clka), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .wea(wea), .addra(addra), .dina(dina), .busy(busy),
    .done(done), .csum(csum)
  );

  int            n_cmp = 0, n_bad = 0;
  logic [WW-1:0] wordv [NW];
  logic [WW-1:0] exp_csum;
  int            idx, cyc, start_cyc, done_cyc, mon_row, mon_writes, mon_dones, stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: row r is stream words r*WPR .. r*WPR+WPR-1, word 0 in the LSBs
  function automatic logic [WW-1:0] model_csum();
    logic [WW-1:0] s = '0;
`ifdef PINV_LOADER_CSUM_EN
    for (int i = 0; i < NW; i++) s = s + wordv[i];
`endif
    return s;
  endfunction

  task automatic monitor();
    if (wea) begin
      chk("wea_addra", 64'(addra), 64'(mon_row));
      for (int k = 0; k < WPR; k++)
        chk("dina_word", 64'(dina[k*WW +: WW]), 64'(wordv[(mon_row % DEPTH)*WPR + k]));
      mon_row++;
      mon_writes++;
    end
    if (done) begin
      mon_dones++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("csum_at_done", 64'(csum), 64'(exp_csum));
    end
  endtask

  // Drive one cycle from negedge+1, sample outputs at the following negedge
  task automatic cycle(input bit v, input bit st);
    bit x;
    s_valid = v;
    start   = st;
    s_data  = (idx < NW) ? wordv[idx] : $urandom;
    x       = v && s_ready;
    @(posedge clka);
    cyc++;
    if (x) idx++;
    @(negedge clka);
    monitor();
    #1;
  endtask

  task automatic run_load(input bit rnd_v, input bit pause3, input bit start7,
                          input bit abort12, input bit chk_lat);
    bit sent7 = 0, v, st;
    int guard = 0, prev;
    idx = 0; mon_row = 0; mon_writes = 0; mon_dones = 0; stall = 0;
    exp_csum = model_csum();
    cycle(1'b1, 1'b1);
    start_cyc = cyc;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (mon_dones == 0 && guard < 4000) begin
      if (abort12 && wea && addra == AW'(12)) begin
        rst_n = 1'b0;
        #1;
        chk("abort_wea", 64'(wea), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(s_ready), 64'd0);
        start = 1'b0; s_valid = 1'b1;
        repeat (2) @(negedge clka);
        #1 rst_n = 1'b1;
        @(negedge clka);
        #1;
        return;
      end
      prev = idx;
      if (stall > 0) begin v = 1'b0; stall--; end
      else v = rnd_v ? ($urandom_range(3) != 0) : 1'b1;
      st = start7 && !sent7 && idx == 7*WPR + 5;
      if (st) sent7 = 1'b1;
      cycle(v, st);
      if (pause3 && idx != prev && (idx == 3*WPR + 11 || idx == 3*WPR + WPR)) stall = 5;
      guard++;
    end
    chk("done_seen", 64'(mon_dones), 64'd1);
    chk("write_count", 64'(mon_writes), 64'(DEPTH));
    if (chk_lat) chk("done_latency", 64'(done_cyc - start_cyc), 64'(1184 + (pause3 ? 9 : 0)));
    repeat (3) cycle(1'b1, 1'b0);
    chk("done_once", 64'(mon_dones), 64'd1);
    chk("no_extra_write", 64'(mon_writes), 64'(DEPTH));
    chk("ready_idle", 64'(s_ready), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("csum_hold", 64'(csum), 64'(exp_csum));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; cyc = 0;
    repeat (4) begin
      @(negedge clka);
      #1;
      start = 1'($urandom); s_valid = 1'($urandom); s_data = $urandom;
    end
    @(negedge clka);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_wea", 64'(wea), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addra", 64'(addra), 64'd0);
    chk("rst_dina", 64'(|dina), 64'd0);
    chk("rst_csum", 64'(csum), 64'd0);
    #1;
    start = 1'b0; s_valid = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    chk("idle_no_accept", 64'(s_ready), 64'd0);

    // Ramp data, no stalls
    for (int i = 0; i < NW; i++) wordv[i] = WW'(i);
    run_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random data, row-3 pauses, stray start in row 7
    for (int i = 0; i < NW; i++) wordv[i] = $urandom;
    run_load(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Random data with random s_valid gaps
    for (int i = 0; i < NW; i++) wordv[i] = $urandom;
    run_load(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during row 12 write, then a clean reload from row 0
    for (int i = 0; i < NW; i++) wordv[i] = $urandom;
    run_load(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("abort_write_stop", 64'(mon_writes), 64'd13);
    for (int i = 0; i < NW; i++) wordv[i] = $urandom;
    run_load(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // All-ones checksum
    for (int i = 0; i < NW; i++) wordv[i] = '1;
    run_load(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PINV_LOADER_CSUM_EN
    chk("csum_all_ones", 64'(csum), 64'h0000_0000_FFFF_FB80);
`else
    chk("csum_all_ones", 64'(csum), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pinv_ram_loader.md
Name: pinv_ram_loader

Overview:
- Write-side counterpart of the pseudo-inverse RAM read port.
- Accepts a narrow stream of 32-bit words, packs each group of 36 words into one 1152-bit row, and writes it through port A (clka, wea, addra, dina).
- Fills all 32 rows, then signals completion so the OMP datapath can start reading.

Parameters:
- ADDR_W, 5, RAM address width.
- DEPTH, 32, number of rows written per load (must be at most 2**ADDR_W).
- WORD_W, 32, input stream word width.
- ROW_W, 1152, RAM row width; must be an exact multiple of WORD_W.
- WORDS_PER_ROW is derived as ROW_W/WORD_W = 36. It is a localparam, not overridable.

Ports:
- clka  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; honoured only in IDLE.
- s_data  in  WORD_W  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data.
- wea  out  1  RAM write enable.
- addra  out  ADDR_W  RAM row address.
- dina  out  ROW_W  RAM write data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last row write.
- csum  out  WORD_W  load checksum (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, s_ready=0, wea=0, addra=0, dina=0, busy=0, done=0, csum=0. Word and row counters are cleared.
- Handshake: a word transfers on a rising edge with s_valid && s_ready. s_data is ignored otherwise. A producer may hold s_valid high indefinitely.
- State machine:
  - IDLE: s_ready=0, busy=0. On start: clear word_cnt, row_cnt and csum; go to FILL; busy=1 from the next cycle.
  - FILL: s_ready=1. Each transfer stores word k (k=word_cnt) into buffer bits [WORD_W*k+WORD_W-1 : WORD_W*k], so word 0 lands in the LSBs, then word_cnt++. On the transfer with word_cnt==WORDS_PER_ROW-1, go to WRITE and wrap word_cnt to 0.
  - WRITE: s_ready=0. Exactly one cycle with wea=1, addra=row_cnt, dina=full buffer. If row_cnt==DEPTH-1, go to DONE; else row_cnt++ and go to FILL.
  - DONE: done=1 for one cycle, busy drops to 0 in the same cycle, csum holds its final value; go to IDLE.
- Throughput: 36 accepted words, then 1 write cycle, per row. Minimum load is 32*37 = 1184 cycles after start.
- Outputs outside WRITE:
  - wea=0 in every state except WRITE.
  - addra and dina hold their last written values (registered outputs).
- Boundaries:
  - start while busy is ignored; no restart, no counter disturbance.
  - start and s_valid in the same IDLE cycle: no word is accepted, because s_ready=0.
  - s_valid low mid-row stalls with no timeout; the partial buffer is retained.
  - row_cnt never wraps within a load; it stops after row DEPTH-1.
  - rst_n asserted mid-load: immediate return to IDLE, wea=0. Partially written RAM contents are not cleaned up; a new start reloads from row 0.
- No combinational path from s_valid to s_ready. s_ready is a registered function of state.

Optional Feature:
- Macro: PINV_LOADER_CSUM_EN.
- Defined: csum = modulo-2**WORD_W sum of every accepted word in the current load.
  - Cleared on start.
  - Updated on each transfer.
  - Final and stable from the done cycle until the next start.
- Undefined: csum is tied to 0 and no adder is synthesised. The port remains present.

Test Plan:
- Reset: hold rst_n=0 with random inputs → s_ready=0, wea=0, busy=0, done=0, addra=0, csum=0.
- Full load with s_valid always high, word value = 36*row+k:
  - exactly 32 wea pulses, on addra 0..31.
  - row r dina bits [31:0]=36r and bits [1151:1120]=36r+35.
  - done pulses once, 1184 cycles after start.
- Backpressure: deassert s_valid for 5 cycles after words 10 and 35 of row 3 → row 3 data is identical to the no-stall case; wea still occurs exactly once for row 3.
- start pulsed during FILL of row 7 → ignored; row_cnt continues and only 32 writes occur in total.
- rst_n dropped during WRITE of row 12 → wea low immediately. A new start then writes rows from addra=0, and row 0 data is correct.
- With PINV_LOADER_CSUM_EN defined, all 1152 words = 32'hFFFF_FFFF → csum = 32'hFFFF_FB80 at done. Without the macro → csum=0.
